// File: rtl/execute_stage.sv
// Execute stage: ID/EX pipeline register, operand forwarding and ALU.
// Clearing the register yields a NOP (AND of zeros, no writes).
module execute_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              FlushE,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic [2:0]        ALUControlD,
    input  logic              ALUSrcD,
    input  logic              RegDstD,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] RD2,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RdD,
    input  logic [DATA_W-1:0] SignImmD,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] ResultW,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic [REG_AW-1:0] RsE,
    output logic [REG_AW-1:0] RtE,
    output logic [REG_AW-1:0] WriteRegE,
    output logic [DATA_W-1:0] ALUOutE,
    output logic [DATA_W-1:0] WriteDataE,
    output logic              ZeroE
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic [2:0]        alu_ctl;
        logic              alu_src;
        logic              reg_dst;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] imm;
    } id_ex_t;

    id_ex_t id_ex_d;
    id_ex_t id_ex_q;

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] fwd_b;
    logic              slt;

    assign id_ex_d = '{
        reg_write:  RegWriteD,
        mem_to_reg: MemtoRegD,
        mem_write:  MemWriteD,
        alu_ctl:    ALUControlD,
        alu_src:    ALUSrcD,
        reg_dst:    RegDstD,
        rd1:        RD1,
        rd2:        RD2,
        rs:         RsD,
        rt:         RtD,
        rd:         RdD,
        imm:        SignImmD
    };

    always_ff @(posedge clk) begin
        if (Reset || FlushE) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    // Forward select 11 is unused and falls back to the register value.
    always_comb begin
        src_a = id_ex_q.rd1;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUOutM;
            default: src_a = id_ex_q.rd1;
        endcase
    end

    always_comb begin
        fwd_b = id_ex_q.rd2;
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUOutM;
            default: fwd_b = id_ex_q.rd2;
        endcase
    end

    assign src_b = id_ex_q.alu_src ? id_ex_q.imm : fwd_b;
    assign slt   = $signed(src_a) < $signed(src_b);

    always_comb begin
        ALUOutE = '0;
        case (id_ex_q.alu_ctl)
            3'b000:  ALUOutE = src_a & src_b;
            3'b001:  ALUOutE = src_a | src_b;
            3'b010:  ALUOutE = src_a + src_b;
            3'b110:  ALUOutE = src_a - src_b;
            3'b111:  ALUOutE = {{(DATA_W-1){1'b0}}, slt};
            default: ALUOutE = '0;
        endcase
    end

    assign ZeroE      = (ALUOutE == '0);
    assign WriteDataE = fwd_b;
    assign RegWriteE  = id_ex_q.reg_write;
    assign MemtoRegE  = id_ex_q.mem_to_reg;
    assign MemWriteE  = id_ex_q.mem_write;
    assign RsE        = id_ex_q.rs;
    assign RtE        = id_ex_q.rt;
    assign WriteRegE  = id_ex_q.reg_dst ? id_ex_q.rd : id_ex_q.rt;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected
// E-side results; a monitor pops and compares one cycle later.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        Reset, FlushE;
    logic        RegWriteD, MemtoRegD, MemWriteD;
    logic [2:0]  ALUControlD;
    logic        ALUSrcD, RegDstD;
    logic [31:0] RD1, RD2, SignImmD;
    logic [4:0]  RsD, RtD, RdD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUOutM, ResultW;
    logic        RegWriteE, MemtoRegE, MemWriteE;
    logic [4:0]  RsE, RtE, WriteRegE;
    logic [31:0] ALUOutE, WriteDataE;
    logic        ZeroE;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] wd;
        logic        z;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_run  = 0;
    int    n_fail = 0;

    execute_stage dut (
        .clk(clk), .Reset(Reset), .FlushE(FlushE),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
        .RD1(RD1), .RD2(RD2), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .SignImmD(SignImmD), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ALUOutM(ALUOutM), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .ALUOutE(ALUOutE),
        .WriteDataE(WriteDataE), .ZeroE(ZeroE)
    );

    always #5 clk = ~clk;

    task automatic d(
        input logic rst, input logic fl,
        input logic rw, input logic m2r, input logic mw,
        input logic [2:0] ctl, input logic src, input logic dst,
        input logic [31:0] a, input logic [31:0] b,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [31:0] imm,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic [31:0] am, input logic [31:0] rwb
    );
        @(negedge clk);
        Reset = rst; FlushE = fl;
        RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw;
        ALUControlD = ctl; ALUSrcD = src; RegDstD = dst;
        RD1 = a; RD2 = b; RsD = rs; RtD = rt; RdD = rd;
        SignImmD = imm; ForwardAE = fa; ForwardBE = fb;
        ALUOutM = am; ResultW = rwb;
    endtask

    task automatic e(
        input string nm,
        input logic rw, input logic m2r, input logic mw,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
        input logic [31:0] alu, input logic [31:0] wd, input logic z
    );
        exp_t x;
        x = '{rw: rw, m2r: m2r, mw: mw, rs: rs, rt: rt, wr: wr,
              alu: alu, wd: wd, z: z};
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: E outputs are valid every cycle, sampled just after the edge.
    initial begin
        exp_t  act, ex;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                nm = name_q.pop_front();
                act = '{rw: RegWriteE, m2r: MemtoRegE, mw: MemWriteE,
                        rs: RsE, rt: RtE, wr: WriteRegE,
                        alu: ALUOutE, wd: WriteDataE, z: ZeroE};
                n_run++;
                if (act !== ex) begin
                    n_fail++;
                    $display("FAIL %s: got rw=%b m2r=%b mw=%b rs=%0d rt=%0d wr=%0d alu=%h wd=%h z=%b, want rw=%b m2r=%b mw=%b rs=%0d rt=%0d wr=%0d alu=%h wd=%h z=%b",
                        nm, act.rw, act.m2r, act.mw, act.rs, act.rt, act.wr,
                        act.alu, act.wd, act.z, ex.rw, ex.m2r, ex.mw,
                        ex.rs, ex.rt, ex.wr, ex.alu, ex.wd, ex.z);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset with nonzero D inputs
        d(1,0, 1,0,0, 3'b010,0,1, 5,7, 3,4,9, 0, 0,0, 0,0);
        e("rst0", 0,0,0, 0,0,0, 32'h0, 32'h0, 1);
        d(1,0, 1,0,0, 3'b010,0,1, 5,7, 3,4,9, 0, 0,0, 0,0);
        e("rst1", 0,0,0, 0,0,0, 32'h0, 32'h0, 1);
        d(0,0, 1,0,0, 3'b010,0,1, 5,7, 3,4,9, 0, 0,0, 0,0);
        e("add", 1,0,0, 3,4,9, 32'd12, 32'd7, 0);
        d(0,0, 1,0,0, 3'b010,1,0, 32'h10,32'hAA, 1,2,3, 32'hFFFFFFFC, 0,0, 0,0);
        e("addi", 1,0,0, 1,2,2, 32'h0C, 32'hAA, 0);
        d(0,0, 1,0,0, 3'b110,0,1, 32'h1234,32'h1234, 6,7,5, 0, 0,0, 0,0);
        e("sub0", 1,0,0, 6,7,5, 32'h0, 32'h1234, 1);
        d(0,0, 1,0,0, 3'b111,0,1, 32'hFFFFFFFF,32'h1, 1,2,8, 0, 0,0, 0,0);
        e("slt_neg", 1,0,0, 1,2,8, 32'h1, 32'h1, 0);
        d(0,0, 1,0,0, 3'b111,0,1, 32'h1,32'hFFFFFFFF, 1,2,8, 0, 0,0, 0,0);
        e("slt_pos", 1,0,0, 1,2,8, 32'h0, 32'hFFFFFFFF, 1);
        d(0,0, 1,0,0, 3'b000,0,1, 32'hF0F0F0F0,32'hFF00FF00, 4,5,6, 0, 0,0, 0,0);
        e("and", 1,0,0, 4,5,6, 32'hF000F000, 32'hFF00FF00, 0);
        d(0,0, 1,0,0, 3'b001,0,1, 32'hF0F0F0F0,32'hFF00FF00, 4,5,6, 0, 0,0, 0,0);
        e("or", 1,0,0, 4,5,6, 32'hFFF0FFF0, 32'hFF00FF00, 0);
        d(0,0, 0,0,0, 3'b011,0,0, 5,7, 4,5,6, 0, 0,0, 0,0);
        e("op011", 0,0,0, 4,5,5, 32'h0, 32'd7, 1);
        d(0,0, 1,0,0, 3'b010,0,1, 1,2, 1,2,3, 0, 2'b10,2'b01, 100,200);
        e("fwd_a10_b01", 1,0,0, 1,2,3, 32'd300, 32'd200, 0);
        d(0,0, 1,0,0, 3'b010,0,1, 1,2, 1,2,3, 0, 2'b11,2'b01, 100,200);
        e("fwd_a11", 1,0,0, 1,2,3, 32'd201, 32'd200, 0);
        d(0,0, 0,0,1, 3'b010,1,0, 1,2, 1,2,3, 32'h1000, 2'b00,2'b10, 100,200);
        e("fwd_b10_imm", 0,0,1, 1,2,2, 32'h1001, 32'd100, 0);
        d(0,0, 1,0,0, 3'b010,0,1, 32'hFFFFFFFF,1, 1,2,3, 0, 0,0, 0,0);
        e("add_wrap", 1,0,0, 1,2,3, 32'h0, 32'h1, 1);
        // flush over a full ADD with writes enabled
        d(0,1, 1,1,1, 3'b010,0,1, 5,7, 3,4,9, 0, 0,0, 0,0);
        e("flush", 0,0,0, 0,0,0, 32'h0, 32'h0, 1);
        d(0,0, 1,1,1, 3'b010,0,1, 5,7, 3,4,9, 0, 0,0, 0,0);
        e("post_flush", 1,1,1, 3,4,9, 32'd12, 32'd7, 0);
        d(0,0, 1,0,0, 3'b110,0,1, 32'h50,32'h20, 7,8,9, 0, 0,0, 0,0);
        e("sub", 1,0,0, 7,8,9, 32'h30, 32'h20, 0);
        d(1,1, 1,0,0, 3'b110,0,1, 32'h50,32'h20, 7,8,9, 0, 0,0, 0,0);
        e("rst_flush", 0,0,0, 0,0,0, 32'h0, 32'h0, 1);
        d(0,0, 1,0,0, 3'b010,0,1, 1,1, 1,2,10, 0, 0,0, 0,0);
        e("b2b0", 1,0,0, 1,2,10, 32'd2, 32'd1, 0);
        d(0,0, 1,0,0, 3'b010,0,1, 2,3, 3,4,11, 0, 0,0, 0,0);
        e("b2b1", 1,0,0, 3,4,11, 32'd5, 32'd3, 0);
        d(0,0, 1,0,0, 3'b001,0,1, 4,8, 5,6,12, 0, 0,0, 0,0);
        e("b2b2", 1,0,0, 5,6,12, 32'd12, 32'd8, 0);
        repeat (3) @(negedge clk);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline stage directly downstream of the decode stage; it holds the ID/EX pipeline register.
- Captures decode control and operands every cycle, resolves EX-stage forwarding, and performs the ALU operation.
- Selects the destination register and presents results to the memory stage and the hazard unit.
- Supports bubble insertion via FlushE (load-use stall, branch/jump flush).

Parameters:
- DATA_W, 32, datapath width (ALU operands, immediates, results).
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- FlushE  input  1  synchronous clear of the ID/EX register (bubble).
- RegWriteD  input  1  decode control.
- MemtoRegD  input  1  decode control.
- MemWriteD  input  1  decode control.
- ALUControlD  input  3  decode ALU operation.
- ALUSrcD  input  1  1 selects SignImm as operand B.
- RegDstD  input  1  1 selects Rd as destination, 0 selects Rt.
- RD1  input  DATA_W  register-file port 1 data.
- RD2  input  DATA_W  register-file port 2 data.
- RsD  input  REG_AW  source register field.
- RtD  input  REG_AW  target register field.
- RdD  input  REG_AW  destination register field.
- SignImmD  input  DATA_W  sign-extended immediate.
- ForwardAE  input  2  forwarding select for operand A.
- ForwardBE  input  2  forwarding select for operand B.
- ALUOutM  input  DATA_W  memory-stage ALU result (forward source).
- ResultW  input  DATA_W  writeback result (forward source).
- RegWriteE  output  1  registered control.
- MemtoRegE  output  1  registered control.
- MemWriteE  output  1  registered control.
- RsE  output  REG_AW  registered Rs, to hazard unit.
- RtE  output  REG_AW  registered Rt, to hazard unit.
- WriteRegE  output  REG_AW  destination register.
- ALUOutE  output  DATA_W  ALU result.
- WriteDataE  output  DATA_W  forwarded operand B before the ALUSrc mux (store data).
- ZeroE  output  1  1 when ALUOutE == 0.

Behaviour:
- ID/EX register holds all D inputs listed above.
- Priority at each rising edge: Reset, then FlushE, then load.
  - Reset or FlushE: every register field cleared to 0.
  - Otherwise: all D inputs captured.
- Cleared state is a NOP: RegWriteE=0, MemWriteE=0, MemtoRegE=0, RsE=RtE=WriteRegE=0, ALUOutE=0 (ALUControl 000 = AND, 0&0), WriteDataE=0, ZeroE=1.
- Latency: one cycle from D inputs to E outputs. All E-side logic downstream of the register is combinational.
- Forwarding is combinational on the current-cycle ALUOutM/ResultW, not registered.
  - 00: register value (RD1E / RD2E).
  - 01: ResultW.
  - 10: ALUOutM.
  - 11: treated as 00.
- SrcAE = forward mux A result.
- WriteDataE = forward mux B result.
- SrcBE = ALUSrcE ? SignImmE : WriteDataE.
- ALU (ALUControlE):
  - 000: AND.
  - 001: OR.
  - 010: ADD (mod 2^DATA_W, carry discarded, no overflow trap).
  - 110: SUB (mod 2^DATA_W).
  - 111: SLT, signed compare; result is 1 if SrcA < SrcB, else 0, zero-extended.
  - 011, 100, 101: result 0.
- WriteRegE = RegDstE ? RdE : RtE.
- Reset or flush asserted mid-stream: the in-flight instruction is discarded. The next non-flushed edge loads normally; there is no residual state.
- FlushE and Reset asserted together: identical result (all zero).
- No stall input: the register loads every non-flush cycle. The hazard unit guarantees a stall in D coincides with FlushE here.

Test Plan:
1. Reset held 2 cycles with nonzero D inputs → all outputs 0, ZeroE=1. First edge after release loads D values.
2. ADD: RD1=5, RD2=7, ALUControlD=010, ALUSrcD=0, RegDstD=1, RdD=9, RegWriteD=1 → next cycle ALUOutE=12, WriteRegE=9, RegWriteE=1, ZeroE=0.
3. Immediate / SUB / SLT:
   - ALUSrcD=1, SignImmD=0xFFFFFFFC, RD1=0x10, ALUControlD=010 → ALUOutE=0x0C. WriteDataE=RD2 unchanged.
   - SUB RD1=RD2=0x1234 → ALUOutE=0, ZeroE=1.
   - SLT RD1=0xFFFFFFFF, RD2=1 → ALUOutE=1.
4. Forwarding: RD1=1, RD2=2, ALUOutM=100, ResultW=200, ADD.
   - ForwardAE=10, ForwardBE=01 → ALUOutE=300.
   - ForwardAE=11 → SrcA=1, ALUOutE=201 (with ForwardBE=01).
   - ForwardBE=10 with ALUSrcD=1 → WriteDataE=100, ALU uses SignImm.
5. Flush: load ADD with RegWriteD=1 and MemWriteD=1, asserting FlushE on that edge → RegWriteE=0, MemWriteE=0, WriteRegE=0. Deassert FlushE → next instruction captured normally.
6. Reset and FlushE asserted together mid-stream after a valid SUB → all zero next cycle. Back-to-back instructions afterwards show 1-cycle latency each with no lost or duplicated entries.
